// File: rtl/fbg_eth_pkg.sv
`default_nettype none
// ============================================================
// fbg_eth_pkg : shared types and constants for the FBG UDP payload path
// Revision 1.0
// ============================================================
package fbg_eth_pkg;

    localparam int HDR_LEN = 4;
    localparam int IDX_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRIME     = 2'd1,
        ST_STREAM    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } frm_state_t;

    function automatic logic [15:0] calc_data_length(input int samples, input int data_w);
        return 16'(HDR_LEN + samples * (IDX_W / 8 + data_w / 8));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_trigger_timer.sv
`default_nettype none
// ============================================================
// pkt_trigger_timer : enable-gated period counter with one-cycle expiry pulse
// Revision 1.0
// ============================================================
module pkt_trigger_timer #(
    parameter int TRIG_PERIOD = 31250
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TRIG_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRIG_PERIOD - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!enable || count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && (count == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/fbg_udp_payload_framer.sv
`default_nettype none
// ============================================================
// fbg_udp_payload_framer : paced UDP payload source serving FBG spectrum slices
// Revision 1.0
// ============================================================
module fbg_udp_payload_framer
    import fbg_eth_pkg::*;
#(
    parameter int SAMPLES_PER_PKT = 300,
    parameter int PKTS_PER_FRAME  = 6,
    parameter int CHANNELS        = 1,
    parameter int DATA_W          = 16,
    parameter int ADDR_W          = 11,
    parameter int TRIG_PERIOD     = 31250
) (
    input  logic              clk125m,
    input  logic              reset,
    input  logic              enable,
    output logic              tx_en_pulse,
    input  logic              tx_done,
    input  logic              payload_req,
    output logic [7:0]        payload_dat,
    output logic [15:0]       data_length,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              overrun,
    output logic              short_pkt
);

    localparam int REC_LEN = IDX_W / 8 + DATA_W / 8;
    localparam logic [2:0]        REC_LAST = 3'(REC_LEN - 1);
    localparam logic [15:0]       S_LAST   = 16'(SAMPLES_PER_PKT - 1);
    localparam logic [15:0]       S_STEP   = 16'(SAMPLES_PER_PKT);
    localparam logic [ADDR_W-1:0] A_STEP   = ADDR_W'(SAMPLES_PER_PKT);
    localparam logic [7:0]        PKT_LAST = 8'(PKTS_PER_FRAME);
    localparam logic [7:0]        CH_LAST  = 8'(CHANNELS - 1);

    frm_state_t        state;
    logic              expire;
    logic [7:0]        pkt_no;
    logic [7:0]        channel;
    logic [15:0]       frame_seq;
    logic [15:0]       pkt_idx0;
    logic [ADDR_W-1:0] pkt_addr0;
    logic [15:0]       cur_idx;
    logic [15:0]       s_cnt;
    logic              in_hdr;
    logic [2:0]        pos;
    logic [DATA_W-1:0] sample;

    pkt_trigger_timer #(
        .TRIG_PERIOD (TRIG_PERIOD)
    ) u_timer (
        .clk    (clk125m),
        .rst    (reset),
        .enable (enable),
        .expire (expire)
    );

    assign data_length = calc_data_length(SAMPLES_PER_PKT, DATA_W);

    always_ff @(posedge clk125m or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            tx_en_pulse <= 1'b0;
            payload_dat <= 8'h00;
            ram_addr    <= '0;
            overrun     <= 1'b0;
            short_pkt   <= 1'b0;
            pkt_no      <= 8'd1;
            channel     <= 8'd0;
            frame_seq   <= 16'd0;
            pkt_idx0    <= 16'd0;
            pkt_addr0   <= '0;
            cur_idx     <= 16'd0;
            s_cnt       <= 16'd0;
            in_hdr      <= 1'b1;
            pos         <= 3'd0;
            sample      <= '0;
        end else begin
            tx_en_pulse <= 1'b0;
            if (expire && state != ST_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (expire) begin
                        tx_en_pulse <= 1'b1;
                        state       <= ST_PRIME;
                        payload_dat <= pkt_no;
                        ram_addr    <= pkt_addr0;
                        cur_idx     <= pkt_idx0 + 16'd1;
                        s_cnt       <= 16'd0;
                        in_hdr      <= 1'b1;
                        pos         <= 3'd0;
                    end
                end

                ST_PRIME, ST_STREAM: begin
                    if (tx_done) begin
                        // Pointers stay put so the same slice is resent next trigger.
                        short_pkt   <= 1'b1;
                        payload_dat <= 8'h00;
                        state       <= ST_IDLE;
                    end else if (payload_req) begin
                        state <= ST_STREAM;
                        if (in_hdr) begin
                            if (pos != 3'd3) begin
                                pos <= pos + 3'd1;
                                case (pos)
                                    3'd0:    payload_dat <= channel;
                                    3'd1:    payload_dat <= frame_seq[7:0];
                                    default: payload_dat <= frame_seq[15:8];
                                endcase
                            end else begin
                                in_hdr      <= 1'b0;
                                pos         <= 3'd0;
                                payload_dat <= cur_idx[7:0];
                                sample      <= ram_dout;
                                if (S_LAST != 16'd0) begin
                                    ram_addr <= ram_addr + ADDR_W'(1);
                                end
                            end
                        end else if (pos != REC_LAST) begin
                            pos <= pos + 3'd1;
                            if (pos == 3'd0) begin
                                payload_dat <= cur_idx[15:8];
                                cur_idx     <= cur_idx + 16'd1;
                            end else begin
                                payload_dat <= sample[7:0];
                                sample      <= sample >> 8;
                            end
                        end else if (s_cnt != S_LAST) begin
                            // Capture this record's sample and prefetch the next one.
                            s_cnt       <= s_cnt + 16'd1;
                            pos         <= 3'd0;
                            payload_dat <= cur_idx[7:0];
                            sample      <= ram_dout;
                            if ((s_cnt + 16'd1) != S_LAST) begin
                                ram_addr <= ram_addr + ADDR_W'(1);
                            end
                        end else begin
                            payload_dat <= 8'h00;
                            state       <= ST_WAIT_DONE;
                        end
                    end
                end

                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        state <= ST_IDLE;
                        if (pkt_no == PKT_LAST) begin
                            pkt_no   <= 8'd1;
                            pkt_idx0 <= 16'd0;
                            if (channel == CH_LAST) begin
                                channel   <= 8'd0;
                                pkt_addr0 <= '0;
                                frame_seq <= frame_seq + 16'd1;
                            end else begin
                                channel   <= channel + 8'd1;
                                pkt_addr0 <= pkt_addr0 + A_STEP;
                            end
                        end else begin
                            pkt_no    <= pkt_no + 8'd1;
                            pkt_idx0  <= pkt_idx0 + S_STEP;
                            pkt_addr0 <= pkt_addr0 + A_STEP;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fbg_udp_payload_framer.md
# fbg_udp_payload_framer

Parametrised payload source for the UDP transmitter in the FBG demodulator. It paces packet transmission from a programmable trigger period. Each packet it serves is one slice of a multi-channel FBG spectrum frame, read from the dual-port sample RAM. The block sits between the sample RAM read port and the `tx_en_pulse`/`payload_req_o`/`payload_dat_i`/`tx_done` interface of `eth_udp_tx_gmii`, all on the 125 MHz domain.

## Interface
- SAMPLES_PER_PKT, 300, samples per UDP packet.
- PKTS_PER_FRAME, 6, packets per channel frame.
- CHANNELS, 1, spectrum channels stored back-to-back in RAM.
- DATA_W, 16, sample width; multiple of 8, 8..32.
- ADDR_W, 11, RAM address width; must satisfy 2^ADDR_W >= CHANNELS*SAMPLES_PER_PKT*PKTS_PER_FRAME.
- TRIG_PERIOD, 31250, clk125m cycles between packet triggers (>= 16).
- clk125m  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; high = trigger timer runs.
- tx_en_pulse  out  1  one-cycle start request to UDP transmitter.
- tx_done  in  1  one-cycle pulse from transmitter at end of frame.
- payload_req  in  1  transmitter consumes `payload_dat` in each cycle this is high.
- payload_dat  out  8  current payload byte, registered.
- data_length  out  16  constant, 4 + SAMPLES_PER_PKT*(2 + DATA_W/8).
- ram_addr  out  ADDR_W  sample RAM read address.
- ram_dout  in  DATA_W  RAM data, valid one cycle after `ram_addr` changes.
- overrun  out  1  sticky: trigger arrived while a packet was in flight.
- short_pkt  out  1  sticky: `tx_done` arrived before all bytes were consumed.

## Operation
- Packet byte layout, LSB-first for multi-byte fields:
  - Header: pkt_no (1..PKTS_PER_FRAME), channel (0..CHANNELS-1), 16-bit frame_seq.
  - Then SAMPLES_PER_PKT records, each: 16-bit idx, then DATA_W/8 data bytes.
- idx = (pkt_no-1)*SAMPLES_PER_PKT + s + 1, where s = 0..SAMPLES_PER_PKT-1 (1-based within channel).
- RAM address = channel*SAMPLES_PER_PKT*PKTS_PER_FRAME + idx - 1.
- States and transitions:
  - IDLE: timer expiry with enable=1 -> tx_en_pulse, go to PRIME. Load header byte 0 into `payload_dat`; drive `ram_addr` for s=0.
  - PRIME: wait for the first `payload_req`, then go to STREAM.
  - STREAM: advance one byte per req cycle. The record's data bytes come from `ram_dout`, captured into a sample register during the idx bytes. The next sample's address is issued on the cycle its preceding record starts. After the last byte is consumed, go to WAIT_DONE.
  - WAIT_DONE: on `tx_done`, advance pointers and return to IDLE.
- Pointer advance order: pkt_no, then channel; frame_seq increments (mod 2^16) when both wrap.
- Bytes requested beyond the end of the packet: `payload_dat`=0x00, no pointer effect.
- `tx_done` in PRIME or STREAM: set short_pkt, return to IDLE, pointers NOT advanced, so the same packet is resent on the next trigger.
- Timer expiry outside IDLE: set overrun, drop the trigger; the timer keeps free-running.
- enable falling mid-packet: current packet completes; no new trigger. The timer clears while enable=0.
- Reset mid-packet: everything returns to reset values immediately; the transmitter is expected to be reset by the same event.

## Timing
- Reset values:
  - tx_en_pulse=0, payload_dat=0x00, ram_addr=0, overrun=0, short_pkt=0.
  - pkt_no=1, channel=0, frame_seq=0, timer=0, state=IDLE.
- First tx_en_pulse occurs TRIG_PERIOD cycles after enable rises; later pulses follow every TRIG_PERIOD cycles.
- `payload_dat` holds byte k in the cycle after the k-th req cycle. Byte 0 is valid from the cycle after tx_en_pulse.
- `payload_req` may drop and resume; the byte holds while req is low.
- RAM read latency is fixed at 1 cycle. The prefetch guarantees data is captured at least 1 cycle before the first data byte, even with back-to-back reqs.
- The timer is a counter of width clog2(TRIG_PERIOD); it wraps at TRIG_PERIOD-1.

## Structure
- Shared package `fbg_eth_pkg`:
  - state enum, header length (4), idx field width (16).
  - a function computing data_length from the parameters.
- Sub-module `pkt_trigger_timer`: enable-gated period counter emitting a one-cycle expiry pulse.
- The framer FSM, byte sequencer and pointers stay in the top of this block.

## Test plan
- Test parameters: SAMPLES_PER_PKT=3, PKTS_PER_FRAME=2, CHANNELS=2, DATA_W=16, TRIG_PERIOD=100. RAM[a]=0xA000+a. Transmitter model: req held for data_length=16 cycles, tx_done 5 cycles later.
- Single packet: enable=1 -> tx_en_pulse at cycle 100; bytes 01 00 00 00 | 01 00 00 A0 | 02 00 01 A0 | 03 00 02 A0.
- Full sequence: 5 triggers -> headers (1,0,0), (2,0,0), (1,1,0), (2,1,0), (1,0,1). Packet (2,1) first record is idx 4, data 0xA009.
- Stalled req: req toggled 1-0-0-1 through the stream -> identical byte sequence, no duplicates or skips.
- Early tx_done after 6 bytes -> short_pkt=1; the next trigger resends the header 01 00 00 00.
- Overrun: transmitter holds tx_done for 150 cycles -> overrun=1; the next tx_en_pulse is at the following period boundary.
- Reset asserted mid-STREAM -> all outputs at reset values next edge; after release the next packet is 01 00 00 00.
